// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite initiator bridge.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_WB    = 3'd2,
        ST_RA    = 3'd3,
        ST_RR    = 3'd4,
        ST_RSP   = 3'd5,
        ST_DRAIN = 3'd6
    } state_t;

    localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

    // EXOKAY counts as success; only SLVERR/DECERR flag an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == SLVERR) || (resp == DECERR);
    endfunction

endpackage

// File: rtl/axil_master_bridge.sv
// Single-outstanding AXI4-Lite initiator: valid/ready request port in,
// AXI4-Lite transaction out, read data / error returned on a response port.
module axil_master_bridge
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    state_t                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  wr_q, wr_d;
    logic                  axi_done_q, axi_done_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;

    logic accept_s, b_hs_s, r_hs_s, ar_hs_s;
    logic aw_left_s, w_left_s, ar_left_s;
    logic axi_fin_s, rsp_gone_s, active_s, tmo_hit_s;
    logic [TMO_W-1:0] tmo_cnt_inc_s;

    assign accept_s   = req_valid & req_ready_q;
    assign b_hs_s     = bready_q & m_axil_bvalid;
    assign r_hs_s     = rready_q & m_axil_rvalid;
    assign ar_hs_s    = arvalid_q & m_axil_arready;
    assign aw_left_s  = awvalid_q & ~m_axil_awready;
    assign w_left_s   = wvalid_q & ~m_axil_wready;
    assign ar_left_s  = arvalid_q & ~m_axil_arready;
    // The AXI side is finished once its B or R beat has been taken (now or earlier).
    assign axi_fin_s  = axi_done_q | b_hs_s | r_hs_s;
    assign rsp_gone_s = ~rsp_valid_q | rsp_ready;
    assign active_s   = (state_q == ST_WR) || (state_q == ST_WB) ||
                        (state_q == ST_RA) || (state_q == ST_RR);
    assign tmo_cnt_inc_s = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
    assign tmo_hit_s  = active_s && (TIMEOUT_CYCLES != 32'd0) && (tmo_cnt_inc_s == TMO_MAX);

    // State register and all registered outputs.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wr_q        <= 1'b0;
            axi_done_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            wr_q        <= wr_d;
            axi_done_q  <= axi_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    // Next-state decode; a completing B/R beat wins over a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = req_write ? ST_WR : ST_RA;
                else          state_d = ST_IDLE;
            end
            ST_WR: begin
                if (tmo_hit_s)                    state_d = ST_DRAIN;
                else if (!aw_left_s && !w_left_s) state_d = ST_WB;
                else                              state_d = ST_WR;
            end
            ST_WB: begin
                if (b_hs_s)         state_d = ST_RSP;
                else if (tmo_hit_s) state_d = ST_DRAIN;
                else                state_d = ST_WB;
            end
            ST_RA: begin
                if (tmo_hit_s)    state_d = ST_DRAIN;
                else if (ar_hs_s) state_d = ST_RR;
                else              state_d = ST_RA;
            end
            ST_RR: begin
                if (r_hs_s)         state_d = ST_RSP;
                else if (tmo_hit_s) state_d = ST_DRAIN;
                else                state_d = ST_RR;
            end
            ST_RSP: begin
                if (rsp_valid_q && rsp_ready) state_d = ST_IDLE;
                else                          state_d = ST_RSP;
            end
            ST_DRAIN: begin
                if (axi_fin_s && rsp_gone_s) state_d = ST_IDLE;
                else                         state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values for the channel flags, response and timeout counter.
    always_comb begin
        req_ready_d = (state_d == ST_IDLE);
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        wr_d        = wr_q;
        axi_done_d  = axi_done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        tmo_cnt_d   = tmo_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    wstrb_d    = req_wstrb;
                    wr_d       = req_write;
                    awvalid_d  = req_write;
                    wvalid_d   = req_write;
                    arvalid_d  = ~req_write;
                    axi_done_d = 1'b0;
                    tmo_cnt_d  = '0;
                end else begin
                    tmo_cnt_d  = tmo_cnt_q;
                end
            end
            ST_WR, ST_WB, ST_RA, ST_RR, ST_DRAIN: begin
                // Same channel rules apply while draining: valids only drop on handshake.
                awvalid_d  = aw_left_s;
                wvalid_d   = w_left_s;
                arvalid_d  = ar_left_s;
                axi_done_d = axi_fin_s;
                bready_d   = wr_q & ~axi_fin_s & ~aw_left_s & ~w_left_s;
                rready_d   = ~wr_q & ~axi_fin_s & ~ar_left_s;
                tmo_cnt_d  = active_s ? tmo_cnt_inc_s : tmo_cnt_q;
                if (state_q == ST_DRAIN) begin
                    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
                    else                          rsp_valid_d = rsp_valid_q;
                end else if (b_hs_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = resp_is_err(m_axil_bresp);
                    rsp_rdata_d = '0;
                end else if (r_hs_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = resp_is_err(m_axil_rresp);
                    rsp_rdata_d = m_axil_rdata;
                end else if (tmo_hit_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    rsp_valid_d = rsp_valid_q;
                end
            end
            ST_RSP: begin
                if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
                else                          rsp_valid_d = rsp_valid_q;
            end
            default: begin
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = AXIL_PROT_DEFAULT;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = AXIL_PROT_DEFAULT;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_master_bridge.sv
// Directed bench for axil_master_bridge with a small BRAM-like AXI4-Lite slave.
module tb_axil_master_bridge;
    import axil_pkg::*;

    localparam int TMO = 16;

    logic        aclk, aresetn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
    logic [2:0]  m_axil_awprot, m_axil_arprot;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
    logic        m_axil_rvalid, m_axil_rready;
    logic [1:0]  m_axil_bresp, m_axil_rresp;

    axil_master_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- slave model ----------------
    logic [31:0] mem [0:15];
    int          aw_lat, w_lat, ar_lat;
    logic [1:0]  rresp_force;
    logic        rdata_force_en;
    logic [31:0] rdata_force;
    int          aw_cnt, w_cnt, ar_cnt;
    logic        aw_got, w_got, s_aw_now, s_w_now;
    logic [31:0] s_merged;

    always_comb begin
        m_axil_awready = m_axil_awvalid && !aw_got && (aw_cnt >= aw_lat);
        m_axil_wready  = m_axil_wvalid && !w_got && (w_cnt >= w_lat);
        m_axil_arready = m_axil_arvalid && !m_axil_rvalid && (ar_cnt >= ar_lat);
        s_aw_now = aw_got || (m_axil_awvalid && m_axil_awready);
        s_w_now  = w_got || (m_axil_wvalid && m_axil_wready);
        s_merged = mem[m_axil_awaddr[5:2]];
        for (int b = 0; b < 4; b++)
            if (m_axil_wstrb[b]) s_merged[8*b +: 8] = m_axil_wdata[8*b +: 8];
    end

    always @(posedge aclk) begin
        if (!aresetn) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            m_axil_bvalid <= 1'b0; m_axil_bresp <= 2'b00;
            m_axil_rvalid <= 1'b0; m_axil_rresp <= 2'b00; m_axil_rdata <= 32'h0;
        end else begin
            aw_cnt <= (m_axil_awvalid && !m_axil_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_axil_wvalid && !m_axil_wready) ? w_cnt + 1 : 0;
            ar_cnt <= (m_axil_arvalid && !m_axil_arready) ? ar_cnt + 1 : 0;
            if (s_aw_now && s_w_now && !m_axil_bvalid) begin
                mem[m_axil_awaddr[5:2]] <= s_merged;
                m_axil_bvalid <= 1'b1;
                m_axil_bresp  <= OKAY;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                aw_got <= s_aw_now;
                w_got  <= s_w_now;
                if (m_axil_bvalid && m_axil_bready) m_axil_bvalid <= 1'b0;
            end
            if (m_axil_arvalid && m_axil_arready) begin
                m_axil_rvalid <= 1'b1;
                m_axil_rdata  <= rdata_force_en ? rdata_force : mem[m_axil_araddr[5:2]];
                m_axil_rresp  <= rresp_force;
            end else if (m_axil_rvalid && m_axil_rready) begin
                m_axil_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // results of the last run_req
    logic [31:0] r_rdata;
    logic        r_err, first_aw, first_w, first_ar;
    int          r_lat, aw_cycles, w_cycles, wdata_bad, bready_early, unstable;

    // Called at a negedge. Cycle 1 is the first cycle after the accept edge.
    task automatic run_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold);
        int  g;
        logic w_done;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data; req_wstrb = strb;
        g = 0;
        while (!req_ready && g < 100) begin @(negedge aclk); g++; end
        if (!req_ready) check("accept_bound", 32'(req_ready), 32'd1);
        @(negedge aclk);
        req_valid = 1'b0;
        r_lat = 1; aw_cycles = 0; w_cycles = 0; wdata_bad = 0; bready_early = 0; unstable = 0;
        w_done = 1'b0;
        first_aw = m_axil_awvalid; first_w = m_axil_wvalid; first_ar = m_axil_arvalid;
        forever begin
            if (m_axil_awvalid) aw_cycles++;
            if (m_axil_wvalid) begin
                w_cycles++;
                if (m_axil_wdata !== data) wdata_bad++;
            end
            if (m_axil_bready && !w_done) bready_early++;
            if (m_axil_wvalid && m_axil_wready) w_done = 1'b1;
            if (rsp_valid || r_lat >= 200) break;
            @(negedge aclk);
            r_lat++;
        end
        if (!rsp_valid) check("rsp_bound", 32'(rsp_valid), 32'd1);
        r_rdata = rsp_rdata; r_err = rsp_err;
        repeat (hold) begin
            @(negedge aclk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== r_rdata || rsp_err !== r_err || req_ready !== 1'b0)
                unstable++;
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, late;
        logic arv_at_30;
        aresetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_wstrb = 4'h0; rsp_ready = 1'b0;
        aw_lat = 0; w_lat = 0; ar_lat = 0; rresp_force = OKAY;
        rdata_force_en = 1'b0; rdata_force = 32'h0;
        repeat (3) @(negedge aclk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_valids", {27'd0, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                             m_axil_bready, m_axil_rready}, 32'd0);
        check("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("prot", {26'd0, m_axil_awprot, m_axil_arprot}, 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);

        // 1: full write then read back; ideal slave gives rsp in cycle 3
        run_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        check("t1_aw_w_at_t1", {30'd0, first_aw, first_w}, 32'd3);
        check("t1_wr_err", 32'(r_err), 32'd0);
        check("t1_wr_lat", 32'(r_lat), 32'd3);
        check("t1_wr_rdata0", r_rdata, 32'd0);
        check("t1_idle_after", 32'(req_ready), 32'd1);
        run_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
        check("t1_ar_at_t1", 32'(first_ar), 32'd1);
        check("t1_rd_data", r_rdata, 32'hDEADBEEF);
        check("t1_rd_err", 32'(r_err), 32'd0);

        // 2: partial strobe merge
        run_req(1'b1, 32'h10, 32'h0000CAFE, 4'h3, 0);
        run_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
        check("t2_rd_merge", r_rdata, 32'hDEADCAFE);

        // 3: wready after 5 cycles
        w_lat = 5;
        run_req(1'b1, 32'h20, 32'h11112222, 4'hF, 0);
        w_lat = 0;
        check("t3_aw_cycles", 32'(aw_cycles), 32'd1);
        check("t3_w_cycles", 32'(w_cycles), 32'd6);
        check("t3_wdata_stable", 32'(wdata_bad), 32'd0);
        check("t3_bready_early", 32'(bready_early), 32'd0);
        check("t3_err", 32'(r_err), 32'd0);
        run_req(1'b0, 32'h20, 32'h0, 4'h0, 0);
        check("t3_rd_back", r_rdata, 32'h11112222);

        // 4: SLVERR on read still returns the data
        rresp_force = SLVERR; rdata_force_en = 1'b1; rdata_force = 32'h12345678;
        run_req(1'b0, 32'h30, 32'h0, 4'h0, 0);
        check("t4_err", 32'(r_err), 32'd1);
        check("t4_rdata", r_rdata, 32'h12345678);
        rresp_force = OKAY;

        // 5: arready withheld past the timeout; slave accepts AR in cycle 41
        ar_lat = 40; rdata_force = 32'hBAD0BAD0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
        @(negedge aclk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 100) begin @(negedge aclk); n++; end
        // rsp_valid rises TMO edges after arvalid rises (arvalid is seen in cycle 1)
        check("t5_tmo_lat", 32'(n), 32'(TMO + 1));
        check("t5_tmo_err", 32'(rsp_err), 32'd1);
        check("t5_tmo_rdata", rsp_rdata, 32'd0);
        check("t5_arvalid_held", 32'(m_axil_arvalid), 32'd1);
        check("t5_req_ready_lo", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(negedge aclk); n++;
        rsp_ready = 1'b0;
        late = 0; arv_at_30 = 1'b0;
        while (!req_ready && n < 150) begin
            if (rsp_valid) late++;
            if (n == 30) arv_at_30 = m_axil_arvalid;
            @(negedge aclk); n++;
        end
        check("t5_arvalid_c30", 32'(arv_at_30), 32'd1);
        // AR handshake in cycle 41, R in 42, IDLE visible in 43
        check("t5_idle_cycle", 32'(n), 32'(ar_lat + 3));
        check("t5_no_late_rsp", 32'(late), 32'd0);
        check("t5_late_discard", rsp_rdata, 32'd0);
        ar_lat = 0; rdata_force_en = 1'b0;
        run_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
        check("t5_recover", r_rdata, 32'hDEADCAFE);
        check("t5_recover_err", 32'(r_err), 32'd0);

        // 6: response held 10 cycles, then reset during WR
        run_req(1'b1, 32'h24, 32'h55AA55AA, 4'hF, 10);
        check("t6_rsp_stable", 32'(unstable), 32'd0);
        check("t6_err", 32'(r_err), 32'd0);
        w_lat = 8;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
        req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
        @(negedge aclk);
        req_valid = 1'b0;
        check("t6_in_wr", 32'(m_axil_wvalid), 32'd1);
        @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        check("t6_rst_valids", {30'd0, m_axil_awvalid, m_axil_wvalid}, 32'd0);
        check("t6_rst_req_ready", 32'(req_ready), 32'd1);
        check("t6_rst_rsp", 32'(rsp_valid), 32'd0);
        aresetn = 1'b1; w_lat = 0;
        @(negedge aclk);
        run_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
        check("t6_abandoned", r_rdata, 32'hDEADCAFE);
        run_req(1'b0, 32'h24, 32'h0, 4'h0, 0);
        check("t6_rd_back", r_rdata, 32'h55AA55AA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
